// File: rtl/lumacode_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lumacode_pkg: shared mode/config types and constants for the Lumacode decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
package lumacode_pkg;

  typedef enum logic [1:0] {
    LC_OFF  = 2'd0,
    LC_2SYM = 2'd1,
    LC_3SYM = 2'd2,
    LC_4SYM = 2'd3
  } lc_mode_e;

  // Bit layout mirrors lumacode_cfg_i: [31:24] th3, [23:16] th2, [15:8] th1, [2] bank, [1:0] mode
  typedef struct packed {
    logic [7:0] th3;
    logic [7:0] th2;
    logic [7:0] th1;
    logic [4:0] rsvd;
    logic       bank;
    lc_mode_e   mode;
  } lc_cfg_t;

  localparam int LAT_RAM = 1;
  localparam int D_BASE  = 2;
  localparam int D_MAX   = 6;

endpackage
`default_nettype wire

// File: rtl/lumacode_slicer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lumacode_slicer: 8-bit luma to 2-bit symbol against three thresholds.
// Revision: 1.0
// ---------------------------------------------------------------------------
module lumacode_slicer
  import lumacode_pkg::*;
(
  input  logic [7:0] luma_i,
  input  logic [7:0] th1_i,
  input  logic [7:0] th2_i,
  input  logic [7:0] th3_i,
  output logic [1:0] sym_o
);

  // Priority order keeps the result defined for non-monotonic thresholds
  always_comb begin
    if (luma_i < th1_i) begin
      sym_o = 2'd0;
    end else if (luma_i < th2_i) begin
      sym_o = 2'd1;
    end else if (luma_i < th3_i) begin
      sym_o = 2'd2;
    end else begin
      sym_o = 2'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lumacode_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lumacode_decoder: groups luma symbols into palette reads, emits aligned RGB.
// Optional LUMACODE_PASSTHRU_EN builds the mode-0 grey passthrough. Revision: 1.0
// ---------------------------------------------------------------------------
module lumacode_decoder #(
  parameter int LAT_RAM = lumacode_pkg::LAT_RAM
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] lumacode_cfg_i,
  input  logic [7:0]  luma_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [8:0]  lumacode_addr_o,
  output logic        lumacode_rden_o,
  input  logic [31:0] lumacode_data_i,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o
);
  import lumacode_pkg::*;

  lc_cfg_t              cfg_q, cfg_d, cfg_in;
  logic                 vs_prev_q, de_prev_q;
  logic [1:0]           ph_q, ph_d, phase;
  logic [7:0]           acc_q, acc_d, acc_base, acc_next;
  logic [8:0]           addr_q, addr_d;
  logic                 rden_q, rden_d;
  logic [LAT_RAM-1:0]   rd_pipe_q;
  logic [23:0]          rgb_q, pix;
  logic [D_MAX-1:0]     de_dl_q, hs_dl_q, vs_dl_q;
  logic [1:0]           sym;
  logic                 vs_rise, de_rise;
  logic [2:0]           tap;
  logic                 unused_bits;

  assign cfg_in  = lc_cfg_t'(lumacode_cfg_i);
  assign vs_rise = vsync_i & ~vs_prev_q;
  assign de_rise = de_i & ~de_prev_q;
  // A vsync rise applies the new config to the very sample that carries it
  assign cfg_d   = vs_rise ? cfg_in : cfg_q;

  lumacode_slicer u_slicer (
    .luma_i (luma_i),
    .th1_i  (cfg_d.th1),
    .th2_i  (cfg_d.th2),
    .th3_i  (cfg_d.th3),
    .sym_o  (sym)
  );

  always_comb begin
    acc_base = de_rise ? 8'd0 : acc_q;
    phase    = de_rise ? 2'd0 : ph_q;
    acc_next = {acc_base[5:0], sym};
    ph_d     = 2'd0;
    acc_d    = 8'd0;
    rden_d   = 1'b0;
    addr_d   = addr_q;
    if (de_i && (cfg_d.mode != LC_OFF)) begin
      // Last phase index equals the mode value (SPP-1)
      if (phase >= cfg_d.mode) begin
        rden_d = 1'b1;
        addr_d = {cfg_d.bank, acc_next};
      end else begin
        ph_d  = phase + 2'd1;
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_q     <= '0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      ph_q      <= 2'd0;
      acc_q     <= 8'd0;
      addr_q    <= 9'd0;
      rden_q    <= 1'b0;
      rd_pipe_q <= '0;
      rgb_q     <= 24'd0;
      de_dl_q   <= '0;
      hs_dl_q   <= '0;
      vs_dl_q   <= '0;
    end else begin
      cfg_q     <= cfg_d;
      vs_prev_q <= vsync_i;
      de_prev_q <= de_i;
      ph_q      <= ph_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      rden_q    <= rden_d;
      rd_pipe_q[0] <= rden_q;
      for (int i = 1; i < LAT_RAM; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
      if (rd_pipe_q[LAT_RAM-1]) begin
        rgb_q <= lumacode_data_i[23:0];
      end
      de_dl_q <= {de_dl_q[D_MAX-2:0], de_i};
      hs_dl_q <= {hs_dl_q[D_MAX-2:0], hsync_i};
      vs_dl_q <= {vs_dl_q[D_MAX-2:0], vsync_i};
    end
  end

  // Tap D-1 of the delay line, D = SPP + D_BASE (mode 0 behaves like SPP=2)
  assign tap     = (cfg_q.mode == LC_OFF) ? 3'd3 : (3'({1'b0, cfg_q.mode}) + 3'(D_BASE));
  assign de_o    = de_dl_q[tap];
  assign hsync_o = hs_dl_q[tap];
  assign vsync_o = vs_dl_q[tap];

`ifdef LUMACODE_PASSTHRU_EN
  logic [3:0][7:0] pass_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pass_q <= '0;
    end else begin
      pass_q <= {pass_q[2:0], luma_i};
    end
  end

  assign pix = (cfg_q.mode == LC_OFF) ? {3{pass_q[3]}} : rgb_q;
`else
  assign pix = (cfg_q.mode == LC_OFF) ? 24'd0 : rgb_q;
`endif

  assign rgb_o           = de_o ? pix : 24'd0;
  assign lumacode_addr_o = addr_q;
  assign lumacode_rden_o = rden_q;
  assign unused_bits     = ^lumacode_data_i[31:24];

endmodule
`default_nettype wire

// File: tb/tb_lumacode_decoder.sv
`default_nettype none
// tb_lumacode_decoder: directed and randomized checks of lumacode_decoder
// against a sample-history reference model and a behavioural palette RAM.
module tb_lumacode_decoder;
  localparam int N = 8192;

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] lu;
    logic [31:0] cfg;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] lumacode_cfg_i;
  logic [7:0]  luma_i;
  logic        de_i, hsync_i, vsync_i;
  logic [8:0]  lumacode_addr_o;
  logic        lumacode_rden_o;
  logic [31:0] lumacode_data_i;
  logic [23:0] rgb_o;
  logic        de_o, hsync_o, vsync_o;

  always #5 clk = ~clk;

  lumacode_decoder dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .lumacode_cfg_i  (lumacode_cfg_i),
    .luma_i          (luma_i),
    .de_i            (de_i),
    .hsync_i         (hsync_i),
    .vsync_i         (vsync_i),
    .lumacode_addr_o (lumacode_addr_o),
    .lumacode_rden_o (lumacode_rden_o),
    .lumacode_data_i (lumacode_data_i),
    .rgb_o           (rgb_o),
    .de_o            (de_o),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o)
  );

  // Palette RAM: registered address, one-clock read latency
  logic [31:0] ram [512];
  logic [31:0] ram_q;
  always @(posedge clk) if (lumacode_rden_o === 1'b1) ram_q <= ram[lumacode_addr_o];
  assign lumacode_data_i = ram_q;

  int total = 0, bad = 0;
  int cyc = 0, base = 0;
  logic        h_de [N], h_hs [N], h_vs [N], h_rd [N];
  logic [7:0]  h_lu [N];
  logic [31:0] h_cfg [N];
  logic [8:0]  h_addr [N];
  logic [31:0] m_cfg, cur_cfg;
  logic [23:0] m_hold;
  logic        e_rd;
  logic [8:0]  e_addr;
  logic [2:0]  e_tim;
  logic [23:0] e_rgb;
  smp_t        sq [$];

  function automatic int sym_of(input logic [7:0] l, input logic [31:0] c);
    if (l < c[15:8]) return 0;
    if (l < c[23:16]) return 1;
    if (l < c[31:24]) return 2;
    return 3;
  endfunction

  // Drive one sample, then derive the outputs expected in the following cycle
  task automatic step(input smp_t s);
    int c, last, mode, spp, run, d, idx, k;
    logic prev_vs;
    if (cyc >= N - 2) begin
      $display("FAIL history overflow cyc=%0d want below %0d", cyc, N - 2);
      $fatal(1);
    end
    @(negedge clk);
    de_i = s.de; hsync_i = s.hs; vsync_i = s.vs; luma_i = s.lu; lumacode_cfg_i = s.cfg;
    prev_vs = (cyc - 1 >= base) ? h_vs[cyc-1] : 1'b0;
    if (s.vs && !prev_vs) m_cfg = s.cfg;
    h_de[cyc] = s.de; h_hs[cyc] = s.hs; h_vs[cyc] = s.vs; h_lu[cyc] = s.lu; h_cfg[cyc] = m_cfg;
    @(posedge clk); #1;
    cyc++;
    c = cyc; last = c - 1;
    mode = int'(h_cfg[last][1:0]);
    spp = mode + 1;
    run = 0;
    k = last;
    while (k >= base && h_de[k] === 1'b1) begin run++; k--; end
    e_rd = (mode != 0) && (run > 0) && (run % spp == 0);
    idx = 0;
    if (e_rd) for (int j = spp; j >= 1; j--) idx = idx * 4 + sym_of(h_lu[c-j], h_cfg[c-j]);
    e_addr = {h_cfg[last][2], 8'(idx)};
    h_rd[c] = e_rd; h_addr[c] = e_addr;
    if (c - 2 >= base + 1 && h_rd[c-2]) m_hold = ram[h_addr[c-2]][23:0];
    d = (mode == 0) ? 4 : spp + 2;
    e_tim = (c - d >= base) ? {h_de[c-d], h_hs[c-d], h_vs[c-d]} : 3'b000;
    if (!e_tim[2]) e_rgb = 24'd0;
`ifdef LUMACODE_PASSTHRU_EN
    else if (mode == 0) e_rgb = {3{h_lu[c-4]}};
`else
    else if (mode == 0) e_rgb = 24'd0;
`endif
    else e_rgb = m_hold;
  endtask

  task automatic push(input logic de, input logic hs, input logic vs, input logic [7:0] lu);
    smp_t s;
    s.de = de; s.hs = hs; s.vs = vs; s.lu = lu; s.cfg = cur_cfg;
    sq.push_back(s);
  endtask

  task automatic push_frame();
    push(0, 0, 1, 8'd0); push(0, 0, 1, 8'd0); push(0, 0, 0, 8'd0); push(0, 1, 0, 8'd0);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push(0, 0, 0, 8'($urandom));
  endtask

  task automatic release_reset();
    @(negedge clk);
    de_i = 0; hsync_i = 0; vsync_i = 0; luma_i = 0;
    rst_n_i = 1'b1;
    base = cyc; m_cfg = 32'd0; m_hold = 24'd0;
  endtask

  task automatic test_reset();
    int n_rd;
    rst_n_i = 1'b0; de_i = 0; hsync_i = 0; vsync_i = 0; luma_i = 0;
    cur_cfg = 32'hC0804001; lumacode_cfg_i = cur_cfg; m_cfg = 0; m_hold = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({rgb_o, de_o, hsync_o, vsync_o, lumacode_rden_o, lumacode_addr_o} !== 38'd0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", {rgb_o, de_o, hsync_o, vsync_o, lumacode_rden_o, lumacode_addr_o});
    end
    release_reset();
    sq.delete(); push_idle(2);
    for (int i = 0; i < 6; i++) push(1, 0, 0, 8'($urandom));
    push_idle(6);
    n_rd = 0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL reset_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL reset_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL reset_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) n_rd++;
    end
    total++; if (n_rd != 0) begin bad++; $display("FAIL reset_mode_off got %0d strobes want 0", n_rd); end
  endtask

  task automatic test_mode1();
    int i1, n_rd, first_rd, n_rgb, first_rgb;
    logic [8:0] a_rd;
    sq.delete(); cur_cfg = 32'hC0804001;
    push_frame(); push_idle(3);
    push(1, 0, 0, 8'd200); i1 = sq.size(); push(1, 0, 0, 8'd30);
    push_idle(8);
    n_rd = 0; first_rd = -1; n_rgb = 0; first_rgb = -1; a_rd = '0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL m1_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL m1_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL m1_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) begin n_rd++; a_rd = lumacode_addr_o; if (first_rd < 0) first_rd = i; end
      if (rgb_o === 24'hAABBCC && de_o === 1'b1) begin n_rgb++; if (first_rgb < 0) first_rgb = i; end
    end
    total++; if (n_rd != 1 || first_rd != i1) begin bad++; $display("FAIL m1_strobe_slot got n=%0d at %0d want 1 at %0d", n_rd, first_rd, i1); end
    total++; if (a_rd !== 9'h00C) begin bad++; $display("FAIL m1_addr got %h want 00c", a_rd); end
    total++; if (n_rgb != 2 || first_rgb != i1 + 2) begin bad++; $display("FAIL m1_rgb_window got n=%0d at %0d want 2 at %0d", n_rgb, first_rgb, i1 + 2); end
  endtask

  task automatic test_mode3();
    int i0, n_rd, n_badaddr, n_b2b, first_de;
    logic prev_rd;
    sq.delete(); cur_cfg = 32'hC0804007;
    push_frame(); push_idle(2);
    i0 = sq.size();
    repeat (4) begin push(1, 0, 0, 8'd250); push(1, 0, 0, 8'd150); push(1, 0, 0, 8'd100); push(1, 0, 0, 8'd10); end
    push_idle(9);
    n_rd = 0; n_badaddr = 0; n_b2b = 0; first_de = -1; prev_rd = 1'b0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL m3_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL m3_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL m3_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) begin n_rd++; if (lumacode_addr_o !== 9'h1E4) n_badaddr++; if (prev_rd) n_b2b++; end
      prev_rd = (lumacode_rden_o === 1'b1);
      if (de_o === 1'b1 && first_de < 0) first_de = i;
    end
    total++; if (n_rd != 4 || n_badaddr != 0 || n_b2b != 0) begin bad++; $display("FAIL m3_line got n=%0d badaddr=%0d b2b=%0d want 4/0/0", n_rd, n_badaddr, n_b2b); end
    total++; if (first_de != i0 + 5) begin bad++; $display("FAIL m3_delay got first de_o at %0d want %0d", first_de, i0 + 5); end
  endtask

  task automatic test_partial();
    int n_rd;
    sq.delete(); cur_cfg = 32'hC0804002;
    push_frame(); push_idle(2);
    for (int i = 0; i < 7; i++) push(1, 0, 0, 8'($urandom));
    push_idle(4); push(0, 1, 0, 8'd0); push_idle(2);
    for (int i = 0; i < 3; i++) push(1, 0, 0, 8'($urandom));
    push_idle(7);
    n_rd = 0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL part_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL part_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL part_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) n_rd++;
    end
    total++; if (n_rd != 3) begin bad++; $display("FAIL part_count got %0d strobes want 3", n_rd); end
  endtask

  task automatic test_switch();
    int n_rd;
    logic [8:0] a_rd;
    sq.delete(); cur_cfg = 32'hC0804001;
    push_frame(); push_idle(2);
    for (int i = 0; i < 8; i++) push(1, 0, 0, 8'($urandom));
    cur_cfg = 32'hC0804003;
    push_idle(3);
    for (int i = 0; i < 8; i++) push(1, 0, 0, 8'($urandom));
    push_idle(3); push_frame();
    for (int i = 0; i < 8; i++) push(1, 0, 0, 8'($urandom));
    push_idle(4);
    cur_cfg = 32'h40C08005;
    push(1, 0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) push(1, 0, 0, 8'($urandom));
    push_idle(8);
    n_rd = 0; a_rd = '0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL sw_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL sw_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL sw_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) begin n_rd++; a_rd = lumacode_addr_o; end
    end
    total++; if (n_rd != 12) begin bad++; $display("FAIL sw_count got %0d strobes want 12", n_rd); end
    total++; if (a_rd[8] !== 1'b1) begin bad++; $display("FAIL sw_same_edge_bank got %b want 1", a_rd[8]); end
  endtask

  task automatic test_reset_midline();
    int n_rd;
    sq.delete(); cur_cfg = 32'hC0804001;
    push_frame(); push_idle(2);
    for (int i = 0; i < 6; i++) push(1, 0, 0, 8'($urandom));
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (rgb_o !== e_rgb || {de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL rm_pre cyc=%0d got %h/%b want %h/%b", cyc, rgb_o, {de_o, hsync_o, vsync_o}, e_rgb, e_tim); end
    end
    @(negedge clk); rst_n_i = 1'b0; #1;
    total++;
    if ({rgb_o, de_o, hsync_o, vsync_o, lumacode_rden_o, lumacode_addr_o} !== 38'd0) begin
      bad++; $display("FAIL rm_async_clear got %h want 0", {rgb_o, de_o, hsync_o, vsync_o, lumacode_rden_o, lumacode_addr_o});
    end
    release_reset();
    sq.delete();
    for (int i = 0; i < 8; i++) push(1, 0, 0, 8'($urandom));
    push_idle(3); push_frame();
    for (int i = 0; i < 4; i++) push(1, 0, 0, 8'($urandom));
    push_idle(6);
    n_rd = 0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL rm_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL rm_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL rm_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) n_rd++;
    end
    total++; if (n_rd != 2) begin bad++; $display("FAIL rm_resume got %0d strobes want 2", n_rd); end
  endtask

  task automatic test_mode0();
    int n_rd, n_grey, n_nz;
    sq.delete(); cur_cfg = 32'hC0804000;
    push_frame(); push_idle(2);
    for (int i = 0; i < 8; i++) push(1, 0, 0, 8'h80);
    push_idle(6);
    n_rd = 0; n_grey = 0; n_nz = 0;
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd) begin bad++; $display("FAIL m0_strobe cyc=%0d got %b want %b", cyc, lumacode_rden_o, e_rd); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL m0_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL m0_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
      if (lumacode_rden_o === 1'b1) n_rd++;
      if (rgb_o === 24'h808080 && de_o === 1'b1) n_grey++;
      if (rgb_o !== 24'd0) n_nz++;
    end
    total++; if (n_rd != 0) begin bad++; $display("FAIL m0_no_reads got %0d strobes want 0", n_rd); end
`ifdef LUMACODE_PASSTHRU_EN
    total++; if (n_grey != 8) begin bad++; $display("FAIL m0_passthru got %0d grey pixels want 8", n_grey); end
`else
    total++; if (n_nz != 0) begin bad++; $display("FAIL m0_blank got %0d nonzero pixels want 0", n_nz); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] fcfg;
    logic [7:0]  a, b;
    sq.delete();
    for (int f = 0; f < 14; f++) begin
      fcfg = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(1, 120)); b = 8'($urandom_range(121, 200));
        fcfg[15:8] = a; fcfg[23:16] = b; fcfg[31:24] = 8'($urandom_range(201, 255));
      end
      cur_cfg = fcfg;
      push_frame();
      for (int l = 0; l < 3; l++) begin
        cur_cfg = $urandom;
        push(0, 1, 0, 8'd0); push_idle(2);
        for (int p = 0; p < int'($urandom_range(1, 13)); p++) push(1, 0, 0, 8'($urandom));
        push_idle(3);
      end
    end
    foreach (sq[i]) begin
      step(sq[i]);
      total++; if (lumacode_rden_o !== e_rd || (e_rd && lumacode_addr_o !== e_addr)) begin bad++; $display("FAIL rnd_strobe cyc=%0d got %b/%h want %b/%h", cyc, lumacode_rden_o, lumacode_addr_o, e_rd, e_addr); end
      total++; if ({de_o, hsync_o, vsync_o} !== e_tim) begin bad++; $display("FAIL rnd_timing cyc=%0d got %b want %b", cyc, {de_o, hsync_o, vsync_o}, e_tim); end
      total++; if (rgb_o !== e_rgb) begin bad++; $display("FAIL rnd_rgb cyc=%0d got %h want %h", cyc, rgb_o, e_rgb); end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = $urandom;
    ram[12] = 32'h00AABBCC;
    test_reset();
    test_mode1();
    test_mode3();
    test_partial();
    test_switch();
    test_reset_midline();
    test_mode0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
